// File: rtl/bw_seq_divider_if.sv
// Start/busy/done request bundle between a requester and bw_seq_divider.
// Operand and result widths follow the divider parameters DW and VW.
interface bw_seq_divider_if #(
    parameter int DW = 12,
    parameter int VW = 5
) ();
    localparam int QW = DW - VW;

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [QW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf
    );
endinterface

// File: rtl/bw_seq_divider.sv
// Signed restoring divider, one quotient bit per cycle; done pulses DW+1 cycles after start.
// No backpressure: start is taken only in IDLE, ignored while busy/done. Optional macro BW_DIV_OVF_CHECK_EN adds saturation + ovf.
module bw_seq_divider #(
    parameter int DW = 12,
    parameter int VW = 5
) (
    input  logic             clk,
    input  logic             rst,
    bw_seq_divider_if.slave  bus
);
    localparam int QW = DW - VW;
    localparam int CW = $clog2(DW);

`ifdef BW_DIV_OVF_CHECK_EN
    localparam logic [QW-1:0] Q_MAX   = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN   = {1'b1, {(QW-1){1'b0}}};
    localparam logic [DW-1:0] POS_LIM = DW'(Q_MAX);
    localparam logic [DW-1:0] NEG_LIM = DW'(Q_MAX) + DW'(1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    // q_q starts as |dividend|; its MSBs shift out while quotient bits shift in at the LSB
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sign_a_q, sign_a_d;
    logic          sign_q_q, sign_q_d;
    logic [QW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          ovf_q, ovf_d;
`ifdef BW_DIV_OVF_CHECK_EN
    logic          zero_q, zero_d;
`endif

    logic [VW:0]   r_shift;
    logic [VW+1:0] trial;

    assign r_shift = {r_q, q_q[DW-1]};
    assign trial   = {1'b0, r_shift} - {2'b00, dvs_q};

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        r_d      = r_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_q_d = sign_q_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
`ifdef BW_DIV_OVF_CHECK_EN
        zero_d   = zero_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_a_d = bus.dividend[DW-1];
                    sign_q_d = bus.dividend[DW-1] ^ bus.divisor[VW-1];
                    // one extra bit so that -2^(W-1) yields its true magnitude
                    q_d      = bus.dividend[DW-1] ? DW'(-{bus.dividend[DW-1], bus.dividend})
                                                  : bus.dividend;
                    dvs_d    = bus.divisor[VW-1]  ? VW'(-{bus.divisor[VW-1], bus.divisor})
                                                  : bus.divisor;
                    r_d      = '0;
                    cnt_d    = '0;
`ifdef BW_DIV_OVF_CHECK_EN
                    zero_d   = (bus.divisor == '0);
`endif
                    state_d  = CALC;
                end
            end

            CALC: begin
                r_d   = trial[VW+1] ? r_shift[VW-1:0] : VW'(trial);
                q_d   = {q_q[DW-2:0], ~trial[VW+1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW-1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                quo_d = sign_q_q ? QW'(-q_q) : QW'(q_q);
                rem_d = sign_a_q ? VW'(-r_q) : r_q;
                ovf_d = 1'b0;
`ifdef BW_DIV_OVF_CHECK_EN
                if (zero_q) begin
                    ovf_d = 1'b1;
                    quo_d = sign_a_q ? Q_MIN : Q_MAX;
                    rem_d = '0;
                end else if (sign_q_q ? (q_q > NEG_LIM) : (q_q > POS_LIM)) begin
                    ovf_d = 1'b1;
                    quo_d = sign_q_q ? Q_MIN : Q_MAX;
                end
`endif
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            r_q      <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_q_q <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
`ifdef BW_DIV_OVF_CHECK_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            r_q      <= r_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_q_q <= sign_q_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
`ifdef BW_DIV_OVF_CHECK_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign bus.busy      = (state_q == CALC) || (state_q == FIX);
    assign bus.done      = (state_q == DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bw_seq_divider.sv
// Scoreboard bench for bw_seq_divider: stimulus pushes model results, a monitor pops on done.
// The reference model uses plain integer division and follows BW_DIV_OVF_CHECK_EN when defined.
module tb_bw_seq_divider;
    localparam int DW = 12;
    localparam int VW = 5;
    localparam int QW = DW - VW;

    typedef struct packed {
        logic [QW-1:0] q;
        logic [VW-1:0] r;
        logic          o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    logic mon_prev_done = 1'b0;

    bw_seq_divider_if #(.DW(DW), .VW(VW)) bus ();

    bw_seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   qt;
        int   rt;
        e.o = 1'b0;
        if (b == 0) begin
`ifdef BW_DIV_OVF_CHECK_EN
            e.o = 1'b1;
            qt  = (a >= 0) ? 63 : -64;
            rt  = 0;
`else
            qt  = (a >= 0) ? 4095 : -4095;
            rt  = a;
`endif
        end else begin
            qt = a / b;
            rt = a % b;
`ifdef BW_DIV_OVF_CHECK_EN
            if (qt > 63) begin
                e.o = 1'b1;
                qt  = 63;
            end else if (qt < -64) begin
                e.o = 1'b1;
                qt  = -64;
            end
`endif
        end
        e.q = qt[QW-1:0];
        e.r = rt[VW-1:0];
        return e;
    endfunction

    // monitor: compare every done pulse against the oldest outstanding expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                check("done_pulse_width", 32'(mon_prev_done), 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got done with no outstanding op, required none");
                end else begin
                    e = sb.pop_front();
                    check("quotient",  32'(bus.quotient),  32'(e.q));
                    check("remainder", 32'(bus.remainder), 32'(e.r));
                    check("ovf",       32'(bus.ovf),       32'(e.o));
                end
            end
            mon_prev_done = bus.done;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            $display("FAIL idle_timeout: still busy after 100 cycles, required idle");
        end
    endtask

    task automatic run_op(input int a, input int b, input bit timing);
        exp_t e;
        int   lat;
        int   busy_cnt;
        e = model(a, b);
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = 12'(a);
        bus.divisor  = 5'(b);
        @(posedge clk);
        sb.push_back(e);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 12'($urandom);
        bus.divisor  = 5'($urandom);
        if (timing) begin
            busy_cnt = bus.busy ? 1 : 0;
            lat = 0;
            while (!bus.done && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
                if (bus.busy) busy_cnt++;
            end
            check("latency", 32'(lat), 32'd13);
            check("busy_cycles", 32'(busy_cnt), 32'd13);
            @(posedge clk);
            #1;
            check("hold_quotient",  32'(bus.quotient),  32'(e.q));
            check("hold_remainder", 32'(bus.remainder), 32'(e.r));
            check("hold_ovf",       32'(bus.ovf),       32'(e.o));
        end
    endtask

    initial begin : stimulus
        int done_cnt;
        int a;
        int b;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",      32'(bus.busy),      32'd0);
        check("reset_done",      32'(bus.done),      32'd0);
        check("reset_quotient",  32'(bus.quotient),  32'd0);
        check("reset_remainder", 32'(bus.remainder), 32'd0);
        check("reset_ovf",       32'(bus.ovf),       32'd0);
        rst = 1'b0;

        run_op(100, 7, 1'b1);
        run_op(-100, 7, 1'b1);
        run_op(100, -7, 1'b1);
        run_op(-100, -7, 1'b1);
        run_op(-2048, -16, 1'b1);
        run_op(-1024, 16, 1'b1);
        run_op(50, 0, 1'b1);
        run_op(-50, 0, 1'b1);
        run_op(2047, 1, 1'b1);

        // start held high: only the first operands count, the next accept lands at k+DW+3
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = 12'(300);
        bus.divisor  = 5'(-9);
        @(posedge clk);
        sb.push_back(model(300, -9));
        #1;
        for (int j = 1; j <= DW + 3; j++) begin
            if (j == DW + 3) begin
                bus.dividend = 12'(-777);
                bus.divisor  = 5'(10);
            end else begin
                bus.dividend = 12'($urandom);
                bus.divisor  = 5'($urandom);
            end
            @(posedge clk);
            if (j == DW + 3) sb.push_back(model(-777, 10));
            #1;
            if (j == DW + 1) check("held_done", 32'(bus.done), 32'd1);
            if (j == DW + 2) check("held_no_early_accept", 32'(bus.busy), 32'd0);
            if (j == DW + 3) check("held_accept", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        wait_idle();

        // reset in the middle of CALC aborts the operation with no done pulse
        bus.start    = 1'b1;
        bus.dividend = 12'(100);
        bus.divisor  = 5'(7);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_done",      32'(bus.done),      32'd0);
        check("abort_quotient",  32'(bus.quotient),  32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        check("abort_ovf",       32'(bus.ovf),       32'd0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op(100, 7, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(4095, 0)) - 2048;
            b = (i % 8 == 7) ? 0 : int'($urandom_range(31, 0)) - 16;
            run_op(a, b, (i % 5 == 0));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bw_seq_divider.md
# bw_seq_divider

Sequential signed divider that inverts the team's Baugh-Wooley 7x5 multiplier. It divides a DW-bit two's-complement dividend by a VW-bit two's-complement divisor and returns a QW = DW−VW bit quotient and a VW-bit remainder using truncating (C-style) division. It uses one restoring-subtract step per clock. It sits beside the multiplier array in the datapath and checks or undoes products through a start/busy/done handshake.

## Interface
- DW, 12, dividend width (bits); must exceed VW
- VW, 5, divisor and remainder width (bits); QW = DW−VW (default 7)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- dividend  input  DW  signed dividend, sampled on accepting edge
- divisor  input  VW  signed divisor, sampled on accepting edge
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse; results valid while high and held afterwards
- quotient  output  QW  signed quotient
- remainder  output  VW  signed remainder, sign of dividend
- ovf  output  1  overflow or divide-by-zero flag (see Configuration)

## Operation
- Reset values: state=IDLE; busy, done, ovf, quotient and remainder are all 0.
- States are IDLE → CALC → FIX → DONE → IDLE.
- **IDLE:** if start=1, latch sign_a, sign_b and sign_q = sign_a^sign_b. Load |dividend| as DW-bit unsigned, load |divisor| as VW-bit unsigned, clear the partial remainder and set count=0. Go to CALC.
- **CALC:** each cycle, shift the next dividend MSB into the partial remainder and trial-subtract |divisor|.
  - If the result is non-negative, keep the difference and shift in quotient bit 1.
  - Otherwise restore and shift in quotient bit 0.
  - After DW iterations, go to FIX.
- **Internal width:** magnitude quotient Q is DW bits and magnitude remainder R is VW bits.
- **Absolute values:** |−2^(DW−1)| and |−2^(VW−1)| are represented correctly as unsigned. Abs values use width+1-bit internal arithmetic or an equivalent.
- **FIX:** register quotient = sign_q ? −Q : Q and remainder = sign_a ? −R : R, truncated to output widths. Apply overflow handling. Go to DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE.
- A zero divisor is treated as positive. The unsigned algorithm then yields Q = all ones and R = |dividend|.
- start is ignored in CALC, FIX and DONE; no queuing.
- dividend and divisor may change freely after the accepting edge.

## Timing
- start is sampled at edge k.
- busy=1 after edge k through edge k+DW+1.
- done=1 between edge k+DW+1 and edge k+DW+2, so latency is DW+1 cycles (13 at defaults).
- A new start is accepted at edge k+DW+3 at the earliest: back-to-back throughput is one op per DW+3 cycles.
- quotient, remainder and ovf change only at the FIX→DONE edge and on reset.
- rst=1 at any edge, including mid-CALC, forces the reset values on that edge and aborts the operation. start is not accepted on an edge where rst=1.

## Configuration
- **BW_DIV_OVF_CHECK_EN defined:**
  - ovf=1 when the signed quotient does not fit in QW bits (Q > 2^(QW−1)−1 if positive, Q > 2^(QW−1) if negative), or when divisor=0.
  - On overflow, quotient saturates to +(2^(QW−1)−1) if sign_q=0, else −2^(QW−1). Remainder is the normal value.
  - On divisor=0, quotient saturates to +max if dividend ≥ 0, else −min, and remainder=0.
- **Undefined:**
  - ovf is tied to 0.
  - quotient and remainder are the plain truncated low bits of the signed results; they wrap silently.
  - Divide-by-zero gives quotient = low QW bits of ±(2^DW−1) and remainder = low VW bits of ±|dividend|.

## Test plan
- dividend=100, divisor=7, start pulsed 1 cycle → done 13 cycles later; quotient=14, remainder=2, ovf=0; busy high for 13 cycles.
- Sign combinations, expected ovf=0 in each case:
  - (−100, 7) → q=−14, r=−2
  - (100, −7) → q=−14, r=2
  - (−100, −7) → q=14, r=−2
- dividend=−2048, divisor=−16 (Q=128):
  - With macro: ovf=1, q=63, r=0.
  - Without macro: ovf=0, q=0, r=0.
  - Boundary case (−1024, 16) → q=−64, ovf=0 in both builds.
- dividend=50, divisor=0:
  - With macro: ovf=1, q=63, r=0.
  - Without macro: q=−1 (7'h7F), r=low 5 bits of 50 = 18.
- start held high continuously with changing operands → only the first operands are used; the next operation is accepted exactly at edge k+DW+3; results of the first operation are unaffected.
- rst asserted at CALC iteration 5 → next edge busy=0, done=0, q=r=0, ovf=0; no done pulse follows. A fresh start (100, 7) then completes correctly in 13 cycles.
